// File: rtl/spi_reg_controller.sv
// Frame-level SPI command decoder: opcode/address/data frames to register bank.
// Optional read timeout logic is enabled by defining SPI_REG_CTRL_TIMEOUT_EN.
module spi_reg_controller #(
    parameter int unsigned RD_TIMEOUT = 255,
    parameter logic [3:0]  STATUS_SIG = 4'h5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cs,
    input  logic [7:0] mosi_byte,
    input  logic       data_ready,
    output logic       enable,
    output logic [7:0] miso_byte,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wr_data,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rd_data,
    input  logic       reg_rd_valid
);

    typedef enum logic [2:0] {
        S_IDLE, S_OPCODE, S_ADDR, S_WDATA, S_RD_WAIT, S_DISCARD
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_cs_s1, r_cs_s2, r_cs_q;
    logic       w_cs_fall, w_cs_rise;
    logic       r_is_read, r_status_req;
    logic       r_err_op, r_err_to, r_err_short;
    logic [7:0] r_resp, r_addr, r_wr_data;
    logic       r_wr_en, r_rd_en, r_enable;
    logic       w_set_err_op, w_set_err_short, w_status_set;
    logic       w_status_load, w_ld_addr, w_wr, w_rd;
    logic       w_in_wait, w_to_hit, w_to_fire;
    logic [7:0] w_status;

    assign w_cs_fall = r_cs_q & ~r_cs_s2;
    assign w_cs_rise = ~r_cs_q & r_cs_s2;
    assign w_in_wait = (r_state == S_RD_WAIT);
    assign w_to_fire = w_in_wait & w_to_hit & ~reg_rd_valid;
    assign w_status  = {w_in_wait, r_err_op, r_err_to, r_err_short, STATUS_SIG};

`ifdef SPI_REG_CTRL_TIMEOUT_EN
    logic [15:0] r_to_cnt;

    assign w_to_hit = (r_to_cnt == 16'(RD_TIMEOUT));

    always_ff @(posedge clk) begin
        if (!reset_n || !w_in_wait) begin
            r_to_cnt <= 16'h0000;
        end else begin
            r_to_cnt <= r_to_cnt + 16'h0001;
        end
    end
`else
    // No counter in this build: a read waits for reg_rd_valid indefinitely.
    assign w_to_hit = 1'b0 && (RD_TIMEOUT != 0);
`endif

    always_comb begin
        w_next          = r_state;
        w_set_err_op    = 1'b0;
        w_set_err_short = 1'b0;
        w_status_set    = 1'b0;
        w_status_load   = 1'b0;
        w_ld_addr       = 1'b0;
        w_wr            = 1'b0;
        w_rd            = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_cs_fall) w_next = S_OPCODE;
            end
            S_OPCODE: begin
                if (data_ready) begin
                    w_next       = (mosi_byte inside {8'h01, 8'h02}) ? S_ADDR : S_DISCARD;
                    w_set_err_op = (mosi_byte > 8'h03);
                    w_status_set = (mosi_byte == 8'h03);
                end
                // A same-cycle byte is decoded before the frame end is applied.
                if (w_cs_rise) begin
                    w_next          = S_IDLE;
                    w_set_err_short = !data_ready || (mosi_byte inside {8'h01, 8'h02});
                    w_status_load   = data_ready && (mosi_byte == 8'h03);
                end
            end
            S_ADDR: begin
                if (data_ready) begin
                    w_ld_addr = 1'b1;
                    w_rd      = r_is_read;
                    w_next    = r_is_read ? S_RD_WAIT : S_WDATA;
                end
                if (w_cs_rise && !(data_ready && r_is_read)) begin
                    w_next          = S_IDLE;
                    w_set_err_short = !data_ready;
                end
            end
            S_WDATA: begin
                w_wr = data_ready;
                if (w_cs_rise) w_next = S_IDLE;
            end
            S_RD_WAIT: begin
                if (reg_rd_valid || w_to_hit) begin
                    w_next = r_cs_s2 ? S_IDLE : S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (w_cs_rise) begin
                    w_next        = S_IDLE;
                    w_status_load = r_status_req;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cs_s1      <= 1'b1;
            r_cs_s2      <= 1'b1;
            r_cs_q       <= 1'b1;
            r_is_read    <= 1'b0;
            r_status_req <= 1'b0;
            r_err_op     <= 1'b0;
            r_err_to     <= 1'b0;
            r_err_short  <= 1'b0;
            r_resp       <= 8'h00;
            r_addr       <= 8'h00;
            r_wr_data    <= 8'h00;
            r_wr_en      <= 1'b0;
            r_rd_en      <= 1'b0;
            r_enable     <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cs_s1  <= cs;
            r_cs_s2  <= r_cs_s1;
            r_cs_q   <= r_cs_s2;
            r_enable <= (w_next != S_RD_WAIT);
            r_wr_en  <= w_wr;
            r_rd_en  <= w_rd;
            if (r_state == S_OPCODE && data_ready) r_is_read <= (mosi_byte == 8'h02);
            if (r_state == S_IDLE || w_status_load) begin
                r_status_req <= 1'b0;
            end else if (w_status_set) begin
                r_status_req <= 1'b1;
            end
            if (w_wr) r_wr_data <= mosi_byte;
            // Address advances the cycle after each write strobe.
            if (w_ld_addr) begin
                r_addr <= mosi_byte;
            end else if (r_wr_en) begin
                r_addr <= r_addr + 8'h01;
            end
            if (w_in_wait && reg_rd_valid) begin
                r_resp <= reg_rd_data;
            end else if (w_to_fire) begin
                r_resp <= 8'hFF;
            end else if (w_status_load) begin
                r_resp <= w_status;
            end
            r_err_op    <= (r_err_op & ~w_status_load) | w_set_err_op;
            r_err_to    <= (r_err_to & ~w_status_load) | w_to_fire;
            r_err_short <= (r_err_short & ~w_status_load) | w_set_err_short;
        end
    end

    assign enable      = r_enable;
    assign miso_byte   = r_resp;
    assign reg_addr    = r_addr;
    assign reg_wr_data = r_wr_data;
    assign reg_wr_en   = r_wr_en;
    assign reg_rd_en   = r_rd_en;

endmodule

// File: tb/tb_spi_reg_controller.sv
// Scoreboard bench for spi_reg_controller with a frame-level reference model.
// Timeout checks apply when SPI_REG_CTRL_TIMEOUT_EN is defined.
module tb_spi_reg_controller;

    logic       clk = 1'b0;
    logic       reset_n, cs, data_ready, reg_rd_valid;
    logic [7:0] mosi_byte, reg_rd_data;
    logic       enable, reg_wr_en, reg_rd_en;
    logic [7:0] miso_byte, reg_addr, reg_wr_data;

    spi_reg_controller #(.RD_TIMEOUT(10), .STATUS_SIG(4'h5)) dut (
        .clk(clk), .reset_n(reset_n), .cs(cs),
        .mosi_byte(mosi_byte), .data_ready(data_ready),
        .enable(enable), .miso_byte(miso_byte),
        .reg_addr(reg_addr), .reg_wr_data(reg_wr_data),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
        .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  tx[$];
    logic [7:0]  m_resp;
    logic        m_err_op, m_err_to, m_err_short;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        mosi_byte  = b;
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
    endtask

    task automatic model_reset();
        m_resp      = 8'h00;
        m_err_op    = 1'b0;
        m_err_to    = 1'b0;
        m_err_short = 1'b0;
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        cs      = 1'b1;
        tick();
        chk("rst_enable", enable, 0);
        chk("rst_wr_en", reg_wr_en, 0);
        chk("rst_rd_en", reg_rd_en, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_wr_data", reg_wr_data, 0);
        chk("rst_miso", miso_byte, 0);
        reset_n = 1'b1;
        tick();
        chk("enable_after_rst", enable, 1);
        model_reset();
        repeat (4) tick();
    endtask

    // lat < 0: the bench never answers the read request.
    task automatic read_phase(input int lat, input logic [7:0] d);
        int cnt;
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            reg_rd_valid = (c == lat);
            reg_rd_data  = (c == lat) ? d : 8'($urandom);
            if (enable) break;
            cnt++;
            tick();
        end
        reg_rd_valid = 1'b0;
        if (lat >= 0) begin
            chk("rd_enable_low", cnt, lat + 1);
            m_resp = d;
        end else begin
`ifdef SPI_REG_CTRL_TIMEOUT_EN
            chk("to_enable_low", cnt, 11);
            m_resp   = 8'hFF;
            m_err_to = 1'b1;
`else
            chk("no_to_enable_low", cnt, 60);
`endif
        end
    endtask

    task automatic do_frame(input int lat, input logic [7:0] rdat);
        int         n;
        logic [7:0] op, addr;
        n    = tx.size();
        op   = (n > 0) ? tx[0] : 8'h00;
        addr = 8'h00;
        chk("miso_frame_start", miso_byte, m_resp);
        cs = 1'b0;
        repeat (4) tick();
        if (n > 0 && op > 8'h03) m_err_op = 1'b1;
        if (n == 0 || (n == 1 && (op == 8'h01 || op == 8'h02))) m_err_short = 1'b1;
        for (int i = 0; i < n; i++) begin
            send(tx[i]);
            if (op == 8'h01 && i == 1) addr = tx[i];
            if (op == 8'h01 && i >= 2) begin
                wr_q.push_back({addr, tx[i]});
                addr = addr + 8'h01;
            end
            if (op == 8'h02 && i == 1) begin
                rd_q.push_back(tx[i]);
                read_phase(lat, rdat);
                break;
            end
            tick();
        end
        repeat (2) tick();
        cs = 1'b1;
        repeat (5) tick();
        if (n > 0 && op == 8'h03) begin
            m_resp = {1'b0, m_err_op, m_err_to, m_err_short, 4'h5};
            m_err_op    = 1'b0;
            m_err_to    = 1'b0;
            m_err_short = 1'b0;
        end
        tx.delete();
    endtask

    initial begin
        int         kind, nb;
        logic [7:0] d;
        reset_n      = 1'b0;
        cs           = 1'b1;
        data_ready   = 1'b0;
        mosi_byte    = 8'h00;
        reg_rd_valid = 1'b0;
        reg_rd_data  = 8'h00;
        model_reset();

        fork
            begin : monitor
                logic       dr_prev;
                logic [15:0] ew;
                logic [7:0]  er;
                dr_prev = 1'b0;
                forever begin
                    @(negedge clk);
                    if (reg_wr_en) begin
                        chk("wr_after_data_ready", dr_prev, 1);
                        if (wr_q.size() == 0) begin
                            chk("wr_unexpected", {reg_addr, reg_wr_data}, 32'hFFFF_FFFF);
                        end else begin
                            ew = wr_q.pop_front();
                            chk("wr_addr_data", {reg_addr, reg_wr_data}, ew);
                        end
                    end
                    if (reg_rd_en) begin
                        if (rd_q.size() == 0) begin
                            chk("rd_unexpected", reg_addr, 32'hFFFF_FFFF);
                        end else begin
                            er = rd_q.pop_front();
                            chk("rd_addr", reg_addr, er);
                        end
                    end
                    dr_prev = data_ready;
                end
            end
        join_none

        repeat (2) tick();
        reset_pulse();

        tx = '{8'h01, 8'h10, 8'hAA, 8'hBB}; do_frame(0, 8'h00);
        tx = '{8'h01, 8'hFF, 8'h11, 8'h22}; do_frame(0, 8'h00);
        tx = '{8'h02, 8'h40};               do_frame(3, 8'h5A);
        tx = '{8'h7E};                      do_frame(0, 8'h00);
        tx = '{8'h03};                      do_frame(0, 8'h00);
        tx = '{8'h03};                      do_frame(0, 8'h00);
        tx = '{8'h00};                      do_frame(0, 8'h00);

        tx = '{8'h02, 8'h20};               do_frame(-1, 8'h00);
`ifdef SPI_REG_CTRL_TIMEOUT_EN
        tx = '{8'h03};                      do_frame(0, 8'h00);
        tx = '{8'h00};                      do_frame(0, 8'h00);
`else
        reset_pulse();
`endif

        tx = '{8'h01};                      do_frame(0, 8'h00);
        tx = '{8'h03};                      do_frame(0, 8'h00);
        tx = '{8'h00};                      do_frame(0, 8'h00);

        // Late read-valid while idle must not disturb the response byte.
        reg_rd_valid = 1'b1;
        reg_rd_data  = 8'hC3;
        tick();
        reg_rd_valid = 1'b0;

        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 5);
            d    = 8'($urandom);
            unique case (kind)
                0: begin
                    nb = $urandom_range(1, 4);
                    tx = '{8'h01, 8'($urandom)};
                    for (int k = 0; k < nb; k++) tx.push_back(8'($urandom));
                    do_frame(0, 8'h00);
                end
                1: begin
                    tx = '{8'h02, 8'($urandom)};
                    do_frame($urandom_range(0, 6), d);
                end
                2: begin tx = '{8'h03}; do_frame(0, 8'h00); end
                3: begin
                    tx = '{8'($urandom_range(4, 255)), 8'($urandom)};
                    do_frame(0, 8'h00);
                end
                4: begin tx = '{8'h00, 8'($urandom)}; do_frame(0, 8'h00); end
                default: begin
                    tx = '{8'($urandom_range(1, 2))};
                    do_frame(0, 8'h00);
                end
            endcase
        end

        cs = 1'b0;
        repeat (4) tick();
        send(8'h01); tick();
        send(8'h10); tick();
        send(8'hAA);
        wr_q.push_back({8'h10, 8'hAA});
        tick();
        reset_pulse();
        tx = '{8'h03}; do_frame(0, 8'h00);
        tx = '{8'h00}; do_frame(0, 8'h00);

        repeat (4) tick();
        chk("wr_q_drained", wr_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
